// File: rtl/sram_req_arbiter_if.sv
// rtl/sram_req_arbiter_if.sv - SRAM-like request/response port bundle
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        uncached;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata, uncached,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata, uncached,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - 2:1 SRAM-like arbiter with in-order response ID FIFO
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                reset,
    sram_req_arbiter_if.slave   i_port,
    sram_req_arbiter_if.slave   d_port,
    sram_req_arbiter_if.master  m_port,
    output logic                stray_data_ok
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [PW:0] DEPTH = (PW+1)'(MAX_OUTSTANDING);

    logic                       lock;
    logic                       lock_src;
    logic [MAX_OUTSTANDING-1:0] id_fifo;
    logic [PW-1:0]              wp;
    logic [PW-1:0]              rp;
    logic [PW:0]                count;

    logic grant_d;
    logic full;
    logic handshake;
    logic nonempty;
    logic pop;
    logic head;

    // A pending unaccepted request keeps its grant so m_* fields stay stable
    assign grant_d   = lock ? lock_src : d_port.req;
    assign full      = (count == DEPTH);
    assign nonempty  = (count != '0);
    assign head      = id_fifo[rp];

    assign m_port.req      = (grant_d ? d_port.req : i_port.req) & ~full & ~reset;
    assign m_port.wr       = grant_d ? d_port.wr       : i_port.wr;
    assign m_port.size     = grant_d ? d_port.size     : i_port.size;
    assign m_port.addr     = grant_d ? d_port.addr     : i_port.addr;
    assign m_port.wstrb    = grant_d ? d_port.wstrb    : i_port.wstrb;
    assign m_port.wdata    = grant_d ? d_port.wdata    : i_port.wdata;
    assign m_port.uncached = grant_d ? d_port.uncached : i_port.uncached;

    assign handshake = m_port.req & m_port.addr_ok;
    assign pop       = m_port.data_ok & nonempty & ~reset;

    assign i_port.addr_ok = handshake & ~grant_d;
    assign d_port.addr_ok = handshake &  grant_d;
    assign i_port.data_ok = pop & ~head;
    assign d_port.data_ok = pop &  head;
    assign i_port.rdata   = m_port.rdata;
    assign d_port.rdata   = m_port.rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock          <= 1'b0;
            lock_src      <= 1'b0;
            id_fifo       <= '0;
            wp            <= '0;
            rp            <= '0;
            count         <= '0;
            stray_data_ok <= 1'b0;
        end else begin
            if (handshake) begin
                lock <= 1'b0;
            end else if (m_port.req) begin
                lock     <= 1'b1;
                lock_src <= grant_d;
            end

            if (handshake) begin
                id_fifo[wp] <= grant_d;
                wp          <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (handshake && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !handshake) begin
                count <= count - 1'b1;
            end

            if (m_port.data_ok && !nonempty) begin
                stray_data_ok <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - directed self-checking bench for sram_req_arbiter
module tb_sram_req_arbiter;
    logic clk;
    logic reset;
    logic stray_data_ok;
    int   n_assert;
    int   n_fail;

    sram_req_arbiter_if i_bus ();
    sram_req_arbiter_if d_bus ();
    sram_req_arbiter_if m_bus ();

    sram_req_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_port        (i_bus),
        .d_port        (d_bus),
        .m_port        (m_bus),
        .stray_data_ok (stray_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        i_bus.req = 0; i_bus.wr = 0; i_bus.size = 2'd2; i_bus.addr = 32'h100;
        i_bus.wstrb = 4'hf; i_bus.wdata = 32'h0; i_bus.uncached = 0;
        d_bus.req = 0; d_bus.wr = 1; d_bus.size = 2'd2; d_bus.addr = 32'h200;
        d_bus.wstrb = 4'h3; d_bus.wdata = 32'h55; d_bus.uncached = 1;
        m_bus.addr_ok = 0; m_bus.data_ok = 0; m_bus.rdata = 32'h0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        // outputs held low in reset regardless of inputs
        i_bus.req = 1; d_bus.req = 1; m_bus.addr_ok = 1; m_bus.data_ok = 1;
        settle();
        check("rst_m_req", m_bus.req, 0);
        check("rst_i_addr_ok", i_bus.addr_ok, 0);
        check("rst_d_addr_ok", d_bus.addr_ok, 0);
        check("rst_i_data_ok", i_bus.data_ok, 0);
        check("rst_d_data_ok", d_bus.data_ok, 0);
        check("rst_count", dut.count, 0);
        check("rst_stray", stray_data_ok, 0);
        next(); reset = 1'b0; idle();

        // instruction only
        next(); i_bus.req = 1; i_bus.addr = 32'h1C000000; m_bus.addr_ok = 1;
        settle();
        check("i_only_m_req", m_bus.req, 1);
        check("i_only_m_addr", m_bus.addr, 32'h1C000000);
        check("i_only_i_addr_ok", i_bus.addr_ok, 1);
        check("i_only_d_addr_ok", d_bus.addr_ok, 0);
        next(); i_bus.req = 0; m_bus.data_ok = 1; m_bus.rdata = 32'h02800000;
        settle();
        check("i_only_count1", dut.count, 1);
        check("i_only_i_data_ok", i_bus.data_ok, 1);
        check("i_only_i_rdata", i_bus.rdata, 32'h02800000);
        check("i_only_d_data_ok", d_bus.data_ok, 0);
        next(); idle();
        settle();
        check("i_only_count0", dut.count, 0);

        // simultaneous: D first, then I; responses D then I
        next(); i_bus.req = 1; d_bus.req = 1; m_bus.addr_ok = 1;
        settle();
        check("sim_m_addr_d", m_bus.addr, 32'h200);
        check("sim_m_wr_d", m_bus.wr, 1);
        check("sim_d_addr_ok", d_bus.addr_ok, 1);
        check("sim_i_addr_ok0", i_bus.addr_ok, 0);
        next(); d_bus.req = 0;
        settle();
        check("sim_m_addr_i", m_bus.addr, 32'h100);
        check("sim_i_addr_ok", i_bus.addr_ok, 1);
        next(); idle(); m_bus.data_ok = 1;
        settle();
        check("sim_resp1_d", d_bus.data_ok, 1);
        check("sim_resp1_i", i_bus.data_ok, 0);
        next();
        settle();
        check("sim_resp2_i", i_bus.data_ok, 1);
        check("sim_resp2_d", d_bus.data_ok, 0);
        next(); idle();

        // lock: I stalled by addr_ok=0 keeps the grant while D rises
        next(); i_bus.req = 1; i_bus.addr = 32'h300;
        settle();
        check("lock_c1_addr", m_bus.addr, 32'h300);
        check("lock_c1_i_addr_ok", i_bus.addr_ok, 0);
        next(); d_bus.req = 1; d_bus.addr = 32'h400;
        settle();
        check("lock_c2_addr", m_bus.addr, 32'h300);
        next();
        settle();
        check("lock_c3_addr", m_bus.addr, 32'h300);
        next(); m_bus.addr_ok = 1;
        settle();
        check("lock_c4_addr", m_bus.addr, 32'h300);
        check("lock_c4_i_addr_ok", i_bus.addr_ok, 1);
        check("lock_c4_d_addr_ok", d_bus.addr_ok, 0);
        next(); i_bus.req = 0;
        settle();
        check("lock_c5_addr", m_bus.addr, 32'h400);
        check("lock_c5_d_addr_ok", d_bus.addr_ok, 1);
        next(); idle(); m_bus.data_ok = 1;
        settle();
        check("lock_resp_i", i_bus.data_ok, 1);
        next();
        settle();
        check("lock_resp_d", d_bus.data_ok, 1);
        next(); idle();

        // full stall at 4 outstanding
        d_bus.req = 1; m_bus.addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("full_fill_addr_ok", d_bus.addr_ok, 1);
            next();
        end
        settle();
        check("full_count4", dut.count, 4);
        check("full_m_req", m_bus.req, 0);
        check("full_d_addr_ok", d_bus.addr_ok, 0);
        next(); m_bus.data_ok = 1;
        settle();
        check("full_pop_m_req", m_bus.req, 0);
        check("full_pop_d_data_ok", d_bus.data_ok, 1);
        next(); m_bus.data_ok = 0;
        settle();
        check("full_count3", dut.count, 3);
        check("full_resume_m_req", m_bus.req, 1);
        check("full_resume_addr_ok", d_bus.addr_ok, 1);
        next(); d_bus.req = 0;
        settle();
        check("full_count4b", dut.count, 4);
        next(); m_bus.data_ok = 1;
        repeat (4) next();
        m_bus.data_ok = 0;
        settle();
        check("full_drained", dut.count, 0);

        // push+pop at count 2 with pointer wrap 3->0
        next(); idle(); i_bus.req = 1; m_bus.addr_ok = 1;
        next(); i_bus.req = 0; d_bus.req = 1;
        next(); d_bus.req = 0; i_bus.req = 1; m_bus.data_ok = 1;
        settle();
        check("pp_count2", dut.count, 2);
        check("pp1_i_data_ok", i_bus.data_ok, 1);
        check("pp1_i_addr_ok", i_bus.addr_ok, 1);
        next(); i_bus.req = 0; d_bus.req = 1;
        settle();
        check("pp2_count2", dut.count, 2);
        check("pp2_d_data_ok", d_bus.data_ok, 1);
        check("pp2_d_addr_ok", d_bus.addr_ok, 1);
        next(); d_bus.req = 0;
        settle();
        check("pp3_count2", dut.count, 2);
        check("pp3_wrap_i_data_ok", i_bus.data_ok, 1);
        check("pp3_wrap_d_data_ok", d_bus.data_ok, 0);
        next();
        settle();
        check("pp4_d_data_ok", d_bus.data_ok, 1);
        next(); idle();
        settle();
        check("pp_count0", dut.count, 0);

        // stray response, then reset with outstanding requests
        check("pre_stray", stray_data_ok, 0);
        next(); m_bus.data_ok = 1;
        settle();
        check("stray_i_data_ok", i_bus.data_ok, 0);
        check("stray_d_data_ok", d_bus.data_ok, 0);
        next(); m_bus.data_ok = 0;
        settle();
        check("stray_flag", stray_data_ok, 1);
        check("stray_count", dut.count, 0);
        d_bus.req = 1; m_bus.addr_ok = 1;
        repeat (3) next();
        d_bus.req = 0;
        settle();
        check("out3_count", dut.count, 3);
        next(); reset = 1; d_bus.req = 1; m_bus.data_ok = 1;
        settle();
        check("mid_rst_count", dut.count, 0);
        check("mid_rst_m_req", m_bus.req, 0);
        check("mid_rst_d_addr_ok", d_bus.addr_ok, 0);
        check("mid_rst_d_data_ok", d_bus.data_ok, 0);
        check("mid_rst_i_data_ok", i_bus.data_ok, 0);
        check("mid_rst_stray", stray_data_ok, 0);
        next(); reset = 0; idle();
        settle();
        check("post_rst_count", dut.count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-to-one arbiter that shares a single SRAM-like request port (the cache/AXI bridge side) between the core's instruction-fetch and data-memory SRAM-like masters. It sits between the core and the memory bridge. It grants one request per cycle, tracks accepted requests in an in-order ID FIFO, and routes each downstream `data_ok`/`rdata` back to the master that issued it. The downstream port is assumed to return responses in acceptance order.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: accepted-but-unanswered requests allowed. Must be a power of two and ≥2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: clock.
  - `reset` in 1: async active-high reset.
- Instruction master (`i_*`):
  - `i_req` in 1; `i_wr` in 1; `i_size` in 2; `i_addr` in 32; `i_wstrb` in 4; `i_wdata` in 32; `i_uncached` in 1: request fields.
  - `i_addr_ok` out 1: request accepted.
  - `i_data_ok` out 1: response for the instruction master.
  - `i_rdata` out 32: read data.
- Data master (`d_*`): same set of signals as the instruction master.
- Downstream (`m_*`):
  - `m_req` out 1; `m_wr` out 1; `m_size` out 2; `m_addr` out 32; `m_wstrb` out 4; `m_wdata` out 32; `m_uncached` out 1: forwarded request.
  - `m_addr_ok` in 1; `m_data_ok` in 1; `m_rdata` in 32: bridge handshake.
- `stray_data_ok` out 1: sticky flag, set when `m_data_ok` arrives with the FIFO empty.

## Operation
- A request handshake completes in the cycle where `m_req & m_addr_ok` is true. That is the only cycle in which the FIFO is pushed.
- Grant selection (combinational, evaluated only when `lock` = 0):
  - The data master has priority.
  - If only `i_req` is high, the instruction master is granted.
- Lock register:
  - Records the granted source when `m_req` = 1 and `m_addr_ok` = 0.
  - While `lock` = 1, the recorded source keeps the grant, so the downstream sees stable request fields even if the other master raises its request.
  - `lock` clears in the cycle the handshake completes.
  - The granted master must hold its request until `addr_ok`. This matches SRAM-like rules.
- `m_*` request fields: a mux of the granted master's fields. They are don't-care when `m_req` = 0.
- `m_req` = granted master's req AND NOT `full`.
- `i_addr_ok` = `m_addr_ok & m_req & (grant == I)`. `d_addr_ok` is symmetric.
- ID FIFO:
  - Depth `MAX_OUTSTANDING`, 1 bit per entry (0 = I, 1 = D).
  - Pointers `wp`/`rp` are log2(D) bits and wrap modulo D.
  - `count` is log2(D)+1 bits.
  - Push on handshake with the granted ID.
  - Pop on `m_data_ok` when `count` ≠ 0.
  - Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full (`count` == D): `m_req` is forced to 0 and no `addr_ok` is issued. Grant and lock state are held. Because a pop at full does not unblock acceptance in the same cycle, `full` is registered-count based only.
- Response routing:
  - `i_data_ok` = `m_data_ok & count≠0 & head==I`. `d_data_ok` is symmetric.
  - `i_rdata` and `d_rdata` both equal `m_rdata` (shared bus).
- Stray response: `m_data_ok` with `count` == 0 causes no pop and no master `data_ok`, and sets `stray_data_ok` until reset.
- Writes and reads are tracked identically. The bridge issues `data_ok` for writes too.

## Timing
- Reset values: `lock` = 0, `wp` = `rp` = 0, `count` = 0, `stray_data_ok` = 0.
- Reset forces `m_req`, `i_addr_ok`, `d_addr_ok`, `i_data_ok` and `d_data_ok` to 0 while asserted, regardless of inputs.
- Latency:
  - Zero-cycle combinational path from `*_req` to `m_req` and from `m_addr_ok` to `*_addr_ok`.
  - Zero-cycle path from `m_data_ok` to `*_data_ok`.
  - No added pipeline stage.
- A request accepted in cycle N can receive `data_ok` in N+1 at the earliest. The FIFO entry is visible at the head from N+1.
- Reset mid-operation: all outstanding IDs are discarded. The bridge is reset by the same signal.
- Back-to-back: one handshake per cycle is sustainable while `count` < D.

## Test plan
- Instruction only: `i_req`=1, `addr` 0x1C000000, `m_addr_ok`=1 every cycle, `m_data_ok` one cycle later with `m_rdata`=0x02800000. Required: `i_addr_ok` in the same cycle; `i_data_ok`=1 with `i_rdata`=0x02800000 next cycle; `d_data_ok` stays 0.
- Simultaneous requests: `i_req` and `d_req` both high, `m_addr_ok`=1. Required: D is granted first (`m_addr`=`d_addr`), I is granted the following cycle; responses go D then I.
- Lock: `i_req` alone with `m_addr_ok`=0 for 3 cycles, and `d_req` rises in cycle 2. Required: `m_addr` stays `i_addr` until `m_addr_ok`; D is granted afterwards.
- Full stall: D=4, four accepted requests and no `data_ok`. Required: `m_req`=0 on the 5th. One `m_data_ok` → acceptance resumes the following cycle; `count` sequence is 4, 3, 4.
- Push and pop in the same cycle at `count`=2. Required: `count` stays 2 and the head ID is correct after the pointer wraps from 3 to 0.
- Stray `m_data_ok` at `count`=0 → `stray_data_ok`=1, no master `data_ok`. Assert `reset` with 3 outstanding → `count`=0, outputs 0.
